alu_issue_queue: RTL and testbench
==================================

# alu_issue_queue

Eight-entry in-order-allocated, out-of-order-issue queue that holds dispatched integer ops (ADD, SUB, ADDI, XOR, ANDI, SRA, LW/SW address) until both source operands are available, then issues the oldest ready op per cycle to the ALU. It sits directly upstream of the ALU: its registered issue outputs drive the ALU's opcode, func3, func7, source_1, source_2 and pd inputs. It captures ALU writeback broadcasts to wake waiting entries.

## Interface
- DEPTH, 8, number of entries (power of two, ≥2)
- PREG_W, 6, physical register tag width
- DATA_W, 32, operand width
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous reset, active low
- flush  in  1  discard all entries (synchronous)
- disp_valid  in  1  dispatch request
- disp_ready  out  1  queue can accept an op this cycle
- disp_opcode / disp_func3 / disp_func7  in  7/3/7  decoded instruction fields
- disp_ps1, disp_ps2  in  PREG_W each  source physical tags
- disp_rdy1, disp_rdy2  in  1 each  source value already valid at dispatch
- disp_val1, disp_val2  in  DATA_W each  source values (val2 carries sign-extended immediate for I/S-type, with disp_rdy2=1)
- disp_pd  in  PREG_W  destination physical tag
- wb_valid  in  1  writeback broadcast valid
- wb_pd  in  PREG_W  writeback tag
- wb_value  in  DATA_W  writeback value
- iss_valid  out  1  issued op valid this cycle
- iss_opcode / iss_func3 / iss_func7  out  7/3/7  to ALU
- iss_src1, iss_src2  out  DATA_W each  to ALU source_1/source_2
- iss_pd  out  PREG_W  to ALU pd
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Collapsing queue: entry 0 oldest; valid entries always contiguous from index 0.
- Entry state: valid, opcode, func3, func7, tag1/2, rdy1/2, val1/2, pd.
- disp_ready = rst_n & (count < DEPTH); uses registered count, no credit for same-cycle issue.
- Dispatch accepted when disp_valid & disp_ready & ~flush; written at index count, minus one if an issue also occurs that cycle.
- Wakeup: when wb_valid and wb_pd ≠ 0, every valid entry with rdyN=0 and tagN==wb_pd sets rdyN=1, valN=wb_value. wb_pd==0 ignored.
- Dispatch bypass: an op dispatched in the same cycle as a matching broadcast (rdyN=0, disp_psN==wb_pd≠0) is stored with rdyN=1, valN=wb_value.
- Select: among registered state, lowest index with valid & rdy1 & rdy2. Wakeups/dispatches of the current cycle are not visible to select until the next cycle.
- Issue: selected entry removed, entries above shift down one; wakeup applies to shifted entries in the same cycle.
- flush dominates: all entries invalid, count 0, dispatch ignored, iss_valid 0 next cycle.

## Timing
- Reset (rst_n=0 at edge): all entries invalid, count=0, iss_valid=0, iss_opcode/func3/func7/src1/src2/pd=0; disp_ready=0 while rst_n low.
- Issue outputs are registered: op selected in cycle N appears on iss_* after edge N, held one cycle; iss_valid=0 cycles drive iss_pd=0 (ALU outputs 0).
- Min latency dispatch→issue: 1 cycle (dispatched with both ready at edge N, iss_valid after edge N+1).
- Wakeup→issue: broadcast at edge N, entry issues after edge N+1 at earliest.
- Full (count==DEPTH): disp_ready=0 even if an issue occurs that cycle.
- Dispatch + issue same cycle: count unchanged.
- No backpressure from ALU; one issue per cycle max.
- Reset or flush mid-stream: no partially issued op; in-flight iss_* registered before the edge still presented that cycle.

## Test plan
- Reset, then dispatch ADD (0110011/000/0000000) rdy1=rdy2=1, val 5 and 7, pd=3 -> iss_valid one cycle later with src1=5, src2=7, pd=3; count returns to 0.
- Dispatch SUB waiting on tag 9 (rdy1=0), then wb_valid pd=9 value 0x10 -> SUB issues the cycle after broadcast with src1=0x10.
- Dispatch op waiting on tag 12 in the same cycle as wb_pd=12 value 0xAA -> stored ready, issues next cycle with src1=0xAA; wb_pd=0 broadcast wakes nothing.
- Fill 8 entries all waiting -> disp_ready=0, count=8; 9th dispatch dropped; wake entry 5 -> issues, count=7, disp_ready=1, order of remaining preserved.
- Entries 0 and 2 both ready -> entry 0 issues first, entry 2 (now index 1) next cycle.
- Flush with 4 entries and concurrent dispatch -> count=0, no iss_valid afterwards; rst_n low mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/alu_issue_queue.sv
// Collapsing out-of-order issue queue in front of the integer ALU.
// Entry 0 is oldest; the oldest ready op issues each cycle through registered outputs.

module alu_iq_wake #(
  parameter int PREG_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              wb_valid,
  input  logic [PREG_W-1:0] wb_pd,
  input  logic [DATA_W-1:0] wb_value,
  input  logic              rdy,
  input  logic [PREG_W-1:0] tag,
  input  logic [DATA_W-1:0] val,
  output logic              rdy_nx,
  output logic [DATA_W-1:0] val_nx
);
  logic hit;

  // Tag 0 is the hardwired zero register and never produces a wakeup.
  assign hit    = wb_valid & (wb_pd != '0) & ~rdy & (tag == wb_pd);
  assign rdy_nx = rdy | hit;
  assign val_nx = hit ? wb_value : val;
endmodule

module alu_issue_queue #(
  parameter int DEPTH  = 8,
  parameter int PREG_W = 6,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [6:0]               disp_opcode,
  input  logic [2:0]               disp_func3,
  input  logic [6:0]               disp_func7,
  input  logic [PREG_W-1:0]        disp_ps1,
  input  logic [PREG_W-1:0]        disp_ps2,
  input  logic                     disp_rdy1,
  input  logic                     disp_rdy2,
  input  logic [DATA_W-1:0]        disp_val1,
  input  logic [DATA_W-1:0]        disp_val2,
  input  logic [PREG_W-1:0]        disp_pd,
  input  logic                     wb_valid,
  input  logic [PREG_W-1:0]        wb_pd,
  input  logic [DATA_W-1:0]        wb_value,
  output logic                     iss_valid,
  output logic [6:0]               iss_opcode,
  output logic [2:0]               iss_func3,
  output logic [6:0]               iss_func7,
  output logic [DATA_W-1:0]        iss_src1,
  output logic [DATA_W-1:0]        iss_src2,
  output logic [PREG_W-1:0]        iss_pd,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic [6:0]        opcode;
    logic [2:0]        func3;
    logic [6:0]        func7;
    logic [PREG_W-1:0] tag1;
    logic [PREG_W-1:0] tag2;
    logic              rdy1;
    logic              rdy2;
    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;
    logic [PREG_W-1:0] pd;
  } ent_t;

  ent_t [DEPTH-1:0] q, q_w, q_n;
  ent_t             disp_ent;

  logic [DEPTH-1:0]             w_rdy1, w_rdy2, ent_rdy;
  logic [DEPTH-1:0][DATA_W-1:0] w_val1, w_val2;
  logic                         d_rdy1, d_rdy2;
  logic [DATA_W-1:0]            d_val1, d_val2;
  logic [IDX_W-1:0]             sel_idx, wr_idx;
  logic                         iss_fire, disp_acc;
  logic [CNT_W-1:0]             count_n;

  // Wakeup is applied to every stored entry, independent of the collapse.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    alu_iq_wake #(.PREG_W(PREG_W), .DATA_W(DATA_W)) u_wake1 (
      .wb_valid(wb_valid), .wb_pd(wb_pd), .wb_value(wb_value),
      .rdy(q[i].rdy1), .tag(q[i].tag1), .val(q[i].val1),
      .rdy_nx(w_rdy1[i]), .val_nx(w_val1[i])
    );
    alu_iq_wake #(.PREG_W(PREG_W), .DATA_W(DATA_W)) u_wake2 (
      .wb_valid(wb_valid), .wb_pd(wb_pd), .wb_value(wb_value),
      .rdy(q[i].rdy2), .tag(q[i].tag2), .val(q[i].val2),
      .rdy_nx(w_rdy2[i]), .val_nx(w_val2[i])
    );
  end

  alu_iq_wake #(.PREG_W(PREG_W), .DATA_W(DATA_W)) u_byp1 (
    .wb_valid(wb_valid), .wb_pd(wb_pd), .wb_value(wb_value),
    .rdy(disp_rdy1), .tag(disp_ps1), .val(disp_val1),
    .rdy_nx(d_rdy1), .val_nx(d_val1)
  );
  alu_iq_wake #(.PREG_W(PREG_W), .DATA_W(DATA_W)) u_byp2 (
    .wb_valid(wb_valid), .wb_pd(wb_pd), .wb_value(wb_value),
    .rdy(disp_rdy2), .tag(disp_ps2), .val(disp_val2),
    .rdy_nx(d_rdy2), .val_nx(d_val2)
  );

  assign disp_ready = rst_n & (count < CNT_W'(DEPTH));
  assign disp_acc   = disp_valid & disp_ready & ~flush;

  always_comb begin
    disp_ent        = '0;
    disp_ent.opcode = disp_opcode;
    disp_ent.func3  = disp_func3;
    disp_ent.func7  = disp_func7;
    disp_ent.tag1   = disp_ps1;
    disp_ent.tag2   = disp_ps2;
    disp_ent.rdy1   = d_rdy1;
    disp_ent.rdy2   = d_rdy2;
    disp_ent.val1   = d_val1;
    disp_ent.val2   = d_val2;
    disp_ent.pd     = disp_pd;
  end

  // Select sees only registered state: this cycle's wakeups count next cycle.
  always_comb begin
    sel_idx  = '0;
    iss_fire = 1'b0;
    ent_rdy  = '0;
    for (int i = 0; i < DEPTH; i++)
      ent_rdy[i] = (CNT_W'(i) < count) & q[i].rdy1 & q[i].rdy2;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_rdy[i]) begin
        sel_idx  = IDX_W'(i);
        iss_fire = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      q_w[i]      = q[i];
      q_w[i].rdy1 = w_rdy1[i];
      q_w[i].val1 = w_val1[i];
      q_w[i].rdy2 = w_rdy2[i];
      q_w[i].val2 = w_val2[i];
    end
  end

  // Only meaningful when disp_acc, which guarantees count < DEPTH.
  assign wr_idx  = IDX_W'(count - CNT_W'(iss_fire));
  assign count_n = count + CNT_W'(disp_acc) - CNT_W'(iss_fire);

  always_comb begin
    q_n = q_w;
    if (iss_fire) begin
      for (int i = 0; i < DEPTH - 1; i++)
        if (IDX_W'(i) >= sel_idx) q_n[i] = q_w[i+1];
    end
    if (disp_acc) q_n[wr_idx] = disp_ent;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q          <= '0;
      count      <= '0;
      iss_valid  <= 1'b0;
      iss_opcode <= '0;
      iss_func3  <= '0;
      iss_func7  <= '0;
      iss_src1   <= '0;
      iss_src2   <= '0;
      iss_pd     <= '0;
    end else if (flush) begin
      count      <= '0;
      iss_valid  <= 1'b0;
      iss_opcode <= '0;
      iss_func3  <= '0;
      iss_func7  <= '0;
      iss_src1   <= '0;
      iss_src2   <= '0;
      iss_pd     <= '0;
    end else begin
      q          <= q_n;
      count      <= count_n;
      iss_valid  <= iss_fire;
      iss_opcode <= iss_fire ? q[sel_idx].opcode : '0;
      iss_func3  <= iss_fire ? q[sel_idx].func3  : '0;
      iss_func7  <= iss_fire ? q[sel_idx].func7  : '0;
      iss_src1   <= iss_fire ? q[sel_idx].val1   : '0;
      iss_src2   <= iss_fire ? q[sel_idx].val2   : '0;
      iss_pd     <= iss_fire ? q[sel_idx].pd     : '0;
    end
  end
endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: table of per-cycle vectors plus
// hand-written fill, flush and mid-stream reset sequences.
module tb_alu_issue_queue;
  localparam logic [6:0] ADD  = 7'b0110011;
  localparam logic [6:0] OPI  = 7'b0010011;
  localparam logic [6:0] SUB7 = 7'b0100000;

  logic        clk = 1'b0;
  logic        rst_n, flush, disp_valid, disp_ready;
  logic [6:0]  disp_opcode, disp_func7, iss_opcode, iss_func7;
  logic [2:0]  disp_func3, iss_func3;
  logic [5:0]  disp_ps1, disp_ps2, disp_pd, wb_pd, iss_pd;
  logic        disp_rdy1, disp_rdy2, wb_valid, iss_valid;
  logic [31:0] disp_val1, disp_val2, wb_value, iss_src1, iss_src2;
  logic [3:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_issue_queue #(.DEPTH(8), .PREG_W(6), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_opcode(disp_opcode), .disp_func3(disp_func3), .disp_func7(disp_func7),
    .disp_ps1(disp_ps1), .disp_ps2(disp_ps2),
    .disp_rdy1(disp_rdy1), .disp_rdy2(disp_rdy2),
    .disp_val1(disp_val1), .disp_val2(disp_val2), .disp_pd(disp_pd),
    .wb_valid(wb_valid), .wb_pd(wb_pd), .wb_value(wb_value),
    .iss_valid(iss_valid), .iss_opcode(iss_opcode), .iss_func3(iss_func3),
    .iss_func7(iss_func7), .iss_src1(iss_src1), .iss_src2(iss_src2),
    .iss_pd(iss_pd), .count(count)
  );

  typedef struct {
    logic dv; logic [6:0] opc; logic [2:0] f3; logic [6:0] f7;
    logic [5:0] ps1; logic r1; logic [31:0] v1;
    logic [5:0] ps2; logic r2; logic [31:0] v2; logic [5:0] pd;
    logic wv; logic [5:0] wpd; logic [31:0] wval; logic fl;
    logic eiv; logic [6:0] eopc; logic [2:0] ef3; logic [6:0] ef7;
    logic [31:0] es1, es2; logic [5:0] epd; logic [3:0] ecnt; logic edr;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t vi();
    vec_t v;
    v = '{default: '0};
    v.r1 = 1'b1; v.r2 = 1'b1;
    return v;
  endfunction

  function automatic vec_t vd(logic [6:0] opc, logic [2:0] f3, logic [6:0] f7,
                              logic [5:0] ps1, logic r1, logic [31:0] v1,
                              logic [5:0] ps2, logic r2, logic [31:0] v2, logic [5:0] pd);
    vec_t v;
    v = vi();
    v.dv = 1'b1; v.opc = opc; v.f3 = f3; v.f7 = f7;
    v.ps1 = ps1; v.r1 = r1; v.v1 = v1; v.ps2 = ps2; v.r2 = r2; v.v2 = v2; v.pd = pd;
    return v;
  endfunction

  function automatic vec_t wb(vec_t v, logic [5:0] wpd, logic [31:0] wval);
    vec_t r;
    r = v; r.wv = 1'b1; r.wpd = wpd; r.wval = wval;
    return r;
  endfunction

  function automatic vec_t ex(vec_t v, logic eiv, logic [6:0] eopc, logic [2:0] ef3,
                              logic [6:0] ef7, logic [31:0] es1, logic [31:0] es2,
                              logic [5:0] epd, logic [3:0] ecnt, logic edr);
    vec_t r;
    r = v; r.eiv = eiv; r.eopc = eopc; r.ef3 = ef3; r.ef7 = ef7;
    r.es1 = es1; r.es2 = es2; r.epd = epd; r.ecnt = ecnt; r.edr = edr;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    flush = 0; disp_valid = 0; disp_opcode = '0; disp_func3 = '0; disp_func7 = '0;
    disp_ps1 = '0; disp_ps2 = '0; disp_rdy1 = 1; disp_rdy2 = 1;
    disp_val1 = '0; disp_val2 = '0; disp_pd = '0;
    wb_valid = 0; wb_pd = '0; wb_value = '0;
  endtask

  task automatic drive(vec_t v);
    disp_valid = v.dv; disp_opcode = v.opc; disp_func3 = v.f3; disp_func7 = v.f7;
    disp_ps1 = v.ps1; disp_rdy1 = v.r1; disp_val1 = v.v1;
    disp_ps2 = v.ps2; disp_rdy2 = v.r2; disp_val2 = v.v2; disp_pd = v.pd;
    wb_valid = v.wv; wb_pd = v.wpd; wb_value = v.wval; flush = v.fl;
  endtask

  task automatic disp_wait(logic [5:0] tag, logic [31:0] v2, logic [5:0] pd);
    idle_in();
    disp_valid = 1; disp_opcode = ADD; disp_ps1 = tag; disp_rdy1 = 0; disp_val2 = v2; disp_pd = pd;
  endtask

  initial begin
    vec_t f;
    int   tags[7];
    // Single ready ADD, SUB waking on src1, bypass at dispatch, tag-0 ignored.
    tv.push_back(ex(vd(ADD,0,0, 0,1,5, 0,1,7, 3),             0,0,0,0, 0,0,0, 1,1));
    tv.push_back(ex(vi(),                                      1,ADD,0,0, 5,7,3, 0,1));
    tv.push_back(ex(vi(),                                      0,0,0,0, 0,0,0, 0,1));
    tv.push_back(ex(vd(ADD,0,SUB7, 9,0,0, 0,1,3, 4),          0,0,0,0, 0,0,0, 1,1));
    tv.push_back(ex(vi(),                                      0,0,0,0, 0,0,0, 1,1));
    tv.push_back(ex(wb(vi(),9,32'h10),                         0,0,0,0, 0,0,0, 1,1));
    tv.push_back(ex(vi(),                                      1,ADD,0,SUB7, 32'h10,3,4, 0,1));
    tv.push_back(ex(wb(vd(OPI,7,0, 12,0,0, 0,1,1, 5),12,32'hAA), 0,0,0,0, 0,0,0, 1,1));
    tv.push_back(ex(vi(),                                      1,OPI,7,0, 32'hAA,1,5, 0,1));
    tv.push_back(ex(wb(vd(ADD,4,0, 0,0,0, 0,1,2, 6),0,32'h55),  0,0,0,0, 0,0,0, 1,1));
    tv.push_back(ex(wb(vi(),0,32'h66),                         0,0,0,0, 0,0,0, 1,1));
    tv.push_back(ex(vi(),                                      0,0,0,0, 0,0,0, 1,1));
    f = vi(); f.fl = 1'b1;
    tv.push_back(ex(f,                                         0,0,0,0, 0,0,0, 0,1));
    // Entries 0 and 2 woken together: oldest first, then the shifted one.
    tv.push_back(ex(vd(ADD,0,0, 21,0,0, 0,1,1, 10),           0,0,0,0, 0,0,0, 1,1));
    tv.push_back(ex(vd(ADD,0,0, 20,0,0, 0,1,2, 11),           0,0,0,0, 0,0,0, 2,1));
    tv.push_back(ex(vd(ADD,0,0, 21,0,0, 0,1,3, 12),           0,0,0,0, 0,0,0, 3,1));
    tv.push_back(ex(wb(vi(),21,32'h30),                        0,0,0,0, 0,0,0, 3,1));
    tv.push_back(ex(vi(),                                      1,ADD,0,0, 32'h30,1,10, 2,1));
    tv.push_back(ex(vi(),                                      1,ADD,0,0, 32'h30,3,12, 1,1));
    tv.push_back(ex(wb(vi(),20,32'h40),                        0,0,0,0, 0,0,0, 1,1));
    tv.push_back(ex(vi(),                                      1,ADD,0,0, 32'h40,2,11, 0,1));
    // Dispatch and issue in the same cycle keep count steady.
    tv.push_back(ex(vd(ADD,0,0, 0,1,1, 0,1,1, 13),            0,0,0,0, 0,0,0, 1,1));
    tv.push_back(ex(vd(ADD,0,0, 0,1,2, 0,1,2, 14),            1,ADD,0,0, 1,1,13, 1,1));
    tv.push_back(ex(vi(),                                      1,ADD,0,0, 2,2,14, 0,1));
    // Second operand waiting on a writeback.
    tv.push_back(ex(vd(ADD,0,0, 0,1,8, 15,0,0, 16),           0,0,0,0, 0,0,0, 1,1));
    tv.push_back(ex(wb(vi(),15,32'h77),                        0,0,0,0, 0,0,0, 1,1));
    tv.push_back(ex(vi(),                                      1,ADD,0,0, 8,32'h77,16, 0,1));
    tv.push_back(ex(vi(),                                      0,0,0,0, 0,0,0, 0,1));

    idle_in();
    rst_n = 0;
    #1;
    chk("disp_ready_in_reset", disp_ready, 0);
    tick(); tick();
    chk("rst_iss_valid", iss_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_iss_pd", iss_pd, 0);
    chk("rst_iss_src1", iss_src1, 0);
    chk("rst_iss_src2", iss_src2, 0);
    chk("rst_iss_opcode", iss_opcode, 0);
    rst_n = 1;
    #1;
    chk("disp_ready_after_reset", disp_ready, 1);

    foreach (tv[k]) begin
      drive(tv[k]);
      tick();
      chk($sformatf("v%0d_iss_valid", k), iss_valid, tv[k].eiv);
      chk($sformatf("v%0d_iss_pd", k), iss_pd, tv[k].epd);
      chk($sformatf("v%0d_count", k), count, tv[k].ecnt);
      chk($sformatf("v%0d_disp_ready", k), disp_ready, tv[k].edr);
      if (tv[k].eiv) begin
        chk($sformatf("v%0d_opcode", k), iss_opcode, tv[k].eopc);
        chk($sformatf("v%0d_func3", k), iss_func3, tv[k].ef3);
        chk($sformatf("v%0d_func7", k), iss_func7, tv[k].ef7);
        chk($sformatf("v%0d_src1", k), iss_src1, tv[k].es1);
        chk($sformatf("v%0d_src2", k), iss_src2, tv[k].es2);
      end
    end

    // Fill all eight entries with waiting ops, drop a ninth, wake entry 5.
    for (int k = 0; k < 8; k++) begin
      disp_wait(6'(30 + k), 32'(k), 6'(40 + k));
      tick();
      chk($sformatf("fill%0d_count", k), count, k + 1);
    end
    chk("full_disp_ready", disp_ready, 0);
    disp_wait(6'd50, 32'd99, 6'd63);
    tick();
    chk("ninth_count", count, 8);
    chk("ninth_iss_valid", iss_valid, 0);
    idle_in(); wb_valid = 1; wb_pd = 35; wb_value = 32'h123;
    tick();
    chk("wake5_count", count, 8);
    idle_in();
    tick();
    chk("e5_iss_valid", iss_valid, 1);
    chk("e5_iss_pd", iss_pd, 45);
    chk("e5_src1", iss_src1, 32'h123);
    chk("e5_src2", iss_src2, 5);
    chk("e5_count", count, 7);
    chk("e5_disp_ready", disp_ready, 1);
    // Remaining entries must keep their own tag/pd/operand pairing after collapse.
    tags = '{33, 37, 30, 36, 31, 34, 32};
    for (int k = 0; k < 7; k++) begin
      idle_in(); wb_valid = 1; wb_pd = 6'(tags[k]); wb_value = 32'(tags[k] * 3);
      tick();
      chk($sformatf("drain%0d_quiet", k), iss_valid, 0);
      idle_in();
      tick();
      chk($sformatf("drain%0d_iss_valid", k), iss_valid, 1);
      chk($sformatf("drain%0d_pd", k), iss_pd, 32'(tags[k] + 10));
      chk($sformatf("drain%0d_src1", k), iss_src1, 32'(tags[k] * 3));
      chk($sformatf("drain%0d_src2", k), iss_src2, 32'(tags[k] - 30));
      chk($sformatf("drain%0d_count", k), count, 32'(6 - k));
    end

    // Flush with a ready entry and a concurrent dispatch.
    for (int k = 1; k <= 3; k++) begin
      disp_wait(6'(k), 32'(k), 6'(k));
      tick();
    end
    idle_in(); disp_valid = 1; disp_opcode = ADD; disp_val1 = 4; disp_val2 = 4; disp_pd = 21;
    tick();
    chk("preflush_count", count, 4);
    idle_in(); flush = 1; disp_valid = 1; disp_opcode = ADD; disp_val1 = 6; disp_val2 = 6; disp_pd = 20;
    tick();
    chk("flush_count", count, 0);
    chk("flush_iss_valid", iss_valid, 0);
    idle_in();
    tick();
    chk("postflush_iss_valid", iss_valid, 0);
    chk("postflush_count", count, 0);
    idle_in(); wb_valid = 1; wb_pd = 1; wb_value = 32'h5;
    tick();
    idle_in();
    tick();
    chk("postflush_wake_iss_valid", iss_valid, 0);
    chk("postflush_wake_count", count, 0);

    // Reset while an entry is about to issue.
    idle_in(); disp_valid = 1; disp_opcode = ADD; disp_val1 = 9; disp_val2 = 9; disp_pd = 22;
    tick();
    chk("prerst_count", count, 1);
    idle_in(); rst_n = 0;
    #1;
    chk("midrst_disp_ready", disp_ready, 0);
    tick();
    chk("midrst_iss_valid", iss_valid, 0);
    chk("midrst_iss_pd", iss_pd, 0);
    chk("midrst_iss_src1", iss_src1, 0);
    chk("midrst_count", count, 0);
    rst_n = 1;
    tick();
    chk("postrst_iss_valid", iss_valid, 0);
    chk("postrst_count", count, 0);
    chk("postrst_disp_ready", disp_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
